// File: rtl/uart_transmitter_pkg.sv
// rtl/uart_transmitter_pkg.sv - shared UART constants, TX state encodings and parity helper
package uart_transmitter_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 868;

  localparam logic [2:0] s_IDLE   = 3'd0;
  localparam logic [2:0] s_START  = 3'd1;
  localparam logic [2:0] s_DATA   = 3'd2;
  localparam logic [2:0] s_PARITY = 3'd3;
  localparam logic [2:0] s_STOP   = 3'd4;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO; pointers wrap modulo DEPTH, occupancy in a separate count
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset: a flush only needs the pointers and count cleared.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART 8-N-1 transmitter with byte FIFO; UART_TX_PARITY_EN adds an even parity bit
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       i_Clock,
  input  logic       i_Reset_N,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done,
  output logic       o_Fifo_Empty,
  output logic       o_Overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  logic [2:0]                state_q, state_d;
  logic [CNT_W-1:0]          clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      overflow_q, overflow_d;

  logic [UART_DATA_BITS-1:0] fifo_data;
  logic [FIFO_CW-1:0]        fifo_count;
  logic                      fifo_pop, fifo_empty, bit_last;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(UART_DATA_BITS)
  ) u_fifo (
    .clk_i   (i_Clock),
    .resetn_i(i_Reset_N),
    .push_i  (i_Tx_DV),
    .data_i  (i_Tx_Byte),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .count_o (fifo_count)
  );

  assign fifo_empty   = (fifo_count == '0);
  assign o_Fifo_Empty = fifo_empty;
  assign o_Tx_Ready   = (fifo_count != FIFO_CW'(FIFO_DEPTH));
  assign o_Overflow   = overflow_q;
  assign bit_last     = (clk_cnt_q == CNT_LAST);
  assign o_Tx_Active  = (state_q != s_IDLE);
  assign o_Tx_Done    = (state_q == s_STOP) && bit_last;

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = (state_q == s_IDLE || bit_last) ? '0 : clk_cnt_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;
    overflow_d = overflow_q | (i_Tx_DV & ~o_Tx_Ready);
    case (state_q)
      s_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          state_d  = s_START;
        end
      end
      s_START: begin
        if (bit_last) begin
          state_d   = s_DATA;
          bit_idx_d = '0;
        end
      end
      s_DATA: begin
        if (bit_last) begin
          if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = s_PARITY;
`else
            state_d = s_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      s_PARITY: begin
        if (bit_last) begin
          state_d = s_STOP;
        end
      end
`endif
      s_STOP: begin
        // Popping on the last stop cycle chains frames with no idle gap.
        if (bit_last) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            state_d  = s_START;
          end else begin
            state_d = s_IDLE;
          end
        end
      end
      default: state_d = s_IDLE;
    endcase
  end

  always_comb begin
    o_Tx_Serial = 1'b1;
    case (state_q)
      s_START: o_Tx_Serial = 1'b0;
      s_DATA:  o_Tx_Serial = shift_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
      s_PARITY: o_Tx_Serial = even_parity(shift_q);
`endif
      default: o_Tx_Serial = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N) begin
      state_q    <= s_IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter (frame model, line decoder, vector table)
module tb_uart_transmitter;

  localparam int C     = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_ready, tx_serial, tx_active, tx_done, fifo_empty, overflow;

  always #5 clk = ~clk;

  uart_transmitter #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_Clock     (clk),
    .i_Reset_N   (rst_n),
    .i_Tx_DV     (tx_dv),
    .i_Tx_Byte   (tx_byte),
    .o_Tx_Ready  (tx_ready),
    .o_Tx_Serial (tx_serial),
    .o_Tx_Active (tx_active),
    .o_Tx_Done   (tx_done),
    .o_Fifo_Empty(fifo_empty),
    .o_Overflow  (overflow)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Frame-level reference: a byte queue plus the start cycle of the frame on the wire.
  byte unsigned m_q[$];
  byte unsigned sent_log[$];
  bit           m_busy = 0;
  bit           m_valid = 0;
  bit           m_ovf = 0;
  int           m_start = 0;
  logic [7:0]   m_cur = 8'h00;

  int done_cnt = 0;
  int done_q[$];

  byte unsigned rx_q[$];
  bit           rx_par_q[$];
  bit           rx_busy = 0;
  int           rx_t = 0;
  int           rx_b = 0;
  int           rx_ferr = 0;
  logic [7:0]   rx_sh = 8'h00;
  bit           rx_par = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    logic [5:0] e, a;
    logic el, ea, ed;
    int k, b;
    bit d, pop, push_ok;
    @(negedge clk);
    if (m_valid) begin
      el = 1'b1; ea = 1'b0; ed = 1'b0;
      if (m_busy) begin
        k  = cyc - m_start;
        b  = k / C;
        ea = 1'b1;
        ed = (k == FRAME - 1);
        if (b == 0) el = 1'b0;
        else if (b <= 8) el = m_cur[b-1];
        else if (b == NBITS - 1) el = 1'b1;
        else el = ^m_cur;
      end
      e = {el, ea, ed, (m_q.size() < DEPTH), (m_q.size() == 0), m_ovf};
      a = {tx_serial, tx_active, tx_done, tx_ready, fifo_empty, overflow};
      check("outputs{ser,act,done,rdy,empty,ovf}", 32'(a), 32'(e));
    end
    if (tx_done === 1'b1) begin
      done_cnt++;
      done_q.push_back(cyc);
    end
    if (!rst_n) begin
      m_q.delete();
      m_busy  = 0;
      m_ovf   = 0;
      m_valid = 1;
    end else if (m_valid) begin
      d       = m_busy && (cyc - m_start == FRAME - 1);
      pop     = (m_q.size() > 0) && (!m_busy || d);
      push_ok = tx_dv && (m_q.size() < DEPTH);
      if (tx_dv && !push_ok) m_ovf = 1;
      if (pop) begin
        m_cur   = m_q.pop_front();
        m_busy  = 1;
        m_start = cyc + 1;
      end else if (d) begin
        m_busy = 0;
      end
      if (push_ok) begin
        m_q.push_back(tx_byte);
        sent_log.push_back(tx_byte);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Independent line receiver sampling mid-bit.
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_busy = 0;
    end else if (!rx_busy) begin
      if (tx_serial === 1'b0) begin
        rx_busy = 1;
        rx_t    = 0;
      end
    end else begin
      rx_t++;
      if (rx_t % C == C / 2) begin
        rx_b = rx_t / C;
        if (rx_b >= 1 && rx_b <= 8) begin
          rx_sh[rx_b-1] = tx_serial;
        end else if (rx_b == NBITS - 1) begin
          if (tx_serial !== 1'b1) rx_ferr++;
          rx_q.push_back(rx_sh);
          rx_par_q.push_back(rx_par);
          rx_busy = 0;
        end else begin
          rx_par = tx_serial;
        end
      end
    end
  end

  task automatic write(input logic [7:0] b);
    tx_dv   = 1'b1;
    tx_byte = b;
    tick();
    tx_dv   = 1'b0;
    tx_byte = 8'($urandom);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic advance_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_active(output int t);
    int n = 0;
    while (tx_active !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (tx_active !== 1'b1) timeout("wait_active");
    t = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(tx_active === 1'b0 && fifo_empty === 1'b1) && n < 20 * FRAME) begin
      tick();
      n++;
    end
    if (!(tx_active === 1'b0 && fifo_empty === 1'b1)) timeout("wait_idle");
    run(4);
  endtask

  task automatic clear_logs();
    sent_log.delete();
    rx_q.delete();
    rx_par_q.delete();
    done_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic compare_rx(input string name);
    check({name, "_count"}, 32'(rx_q.size()), 32'(sent_log.size()));
    while (rx_q.size() > 0 && sent_log.size() > 0)
      check({name, "_byte"}, 32'(rx_q.pop_front()), 32'(sent_log.pop_front()));
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
    logic       parity;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int         t0, wc, bound;
    logic [10:0] frame;
    bit         ready_low;
    logic [7:0] wr[6];

    vecs[0] = '{8'hA5, 10'b1_1010_0101_0, 1'b0};
    vecs[1] = '{8'h00, 10'b1_0000_0000_0, 1'b0};
    vecs[2] = '{8'hFF, 10'b1_1111_1111_0, 1'b0};
    vecs[3] = '{8'h3C, 10'b1_0011_1100_0, 1'b0};
    vecs[4] = '{8'h07, 10'b1_0000_0111_0, 1'b1};
    vecs[5] = '{8'h03, 10'b1_0000_0011_0, 1'b0};
    vecs[6] = '{8'h80, 10'b1_1000_0000_0, 1'b1};

    @(posedge clk);
    #1;
    do_reset();
    check("reset_serial", 32'(tx_serial), 32'd1);
    check("reset_active", 32'(tx_active), 32'd0);
    check("reset_done", 32'(tx_done), 32'd0);
    check("reset_ready", 32'(tx_ready), 32'd1);
    check("reset_empty", 32'(fifo_empty), 32'd1);
    check("reset_overflow", 32'(overflow), 32'd0);

    // Single frames from the vector table: latency, bit pattern, done position.
    foreach (vecs[i]) begin
      clear_logs();
      wc = cyc;
      write(vecs[i].data);
      wait_active(t0);
      check("start_latency", 32'(t0 - wc), 32'd2);
`ifdef UART_TX_PARITY_EN
      frame = {vecs[i].bits[9], vecs[i].parity, vecs[i].bits[8:0]};
`else
      frame = {1'b1, vecs[i].bits};
`endif
      for (int b = 0; b < NBITS; b++) begin
        advance_to(t0 + b * C + C / 2);
        check("frame_bit", 32'(tx_serial), 32'(frame[b]));
      end
      bound = 0;
      while (tx_done !== 1'b1 && bound < FRAME) begin
        tick();
        bound++;
      end
      if (tx_done !== 1'b1) timeout("wait_done");
      check("done_offset", 32'(cyc - wc), 32'(FRAME + 1));
      wait_idle();
      check("done_pulses", 32'(done_cnt), 32'd1);
`ifdef UART_TX_PARITY_EN
      if (rx_par_q.size() > 0) check("parity_bit", 32'(rx_par_q[0]), 32'(vecs[i].parity));
`endif
      compare_rx("table_rx");
    end

    // Back-to-back frames from consecutive writes.
    clear_logs();
    tx_dv = 1'b1;
    tx_byte = 8'h00; tick();
    tx_byte = 8'hFF; tick();
    tx_byte = 8'h55; tick();
    tx_dv = 1'b0;
    wait_idle();
    check("b2b_done_pulses", 32'(done_cnt), 32'd3);
    if (done_q.size() == 3) begin
      check("b2b_gap1", 32'(done_q[1] - done_q[0]), 32'(FRAME));
      check("b2b_gap2", 32'(done_q[2] - done_q[1]), 32'(FRAME));
    end
    compare_rx("b2b_rx");

    // Overfill: six consecutive writes, the sixth is dropped.
    clear_logs();
    ready_low = 0;
    for (int i = 0; i < 6; i++) begin
      wr[i]   = 8'($urandom);
      tx_dv   = 1'b1;
      tx_byte = wr[i];
      if (tx_ready === 1'b0) ready_low = 1;
      tick();
    end
    tx_dv = 1'b0;
    check("ovf_ready_low_seen", 32'(ready_low), 32'd1);
    check("ovf_set", 32'(overflow), 32'd1);
    wait_idle();
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_accepted", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (rx_q.size() > 0) check("ovf_order", 32'(rx_q.pop_front()), 32'(wr[i]));

    // Reset during data bit 3 of 0x3C with two bytes queued.
    clear_logs();
    tx_dv = 1'b1;
    tx_byte = 8'h3C; tick();
    tx_byte = 8'h11; tick();
    tx_byte = 8'h22; tick();
    tx_dv = 1'b0;
    wait_active(t0);
    advance_to(t0 + 4 * C + 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_serial", 32'(tx_serial), 32'd1);
    check("abort_active", 32'(tx_active), 32'd0);
    check("abort_empty", 32'(fifo_empty), 32'd1);
    check("abort_overflow", 32'(overflow), 32'd0);
    clear_logs();
    run(2 * FRAME);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_no_rx", 32'(rx_q.size()), 32'd0);
    write(8'h5A);
    wait_idle();
    compare_rx("post_abort_rx");

    // Random traffic against the frame model and the line decoder.
    clear_logs();
    for (int i = 0; i < 2000; i++) begin
      tx_dv   = ($urandom_range(0, 5) == 0);
      tx_byte = 8'($urandom);
      tick();
    end
    tx_dv = 1'b0;
    wait_idle();
    compare_rx("random_rx");
    check("framing_errors", 32'(rx_ferr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
